// File: rtl/exec_pkg.sv
// Shared definitions for the parametrised execution unit: op encodings,
// flag bit positions and sequencer states.
package exec_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_SHL = 4'h4;
   localparam logic [3:0] OP_SHR = 4'h5;
   localparam logic [3:0] OP_CMP = 4'h6;
   localparam logic [3:0] OP_DEC = 4'h7;
   localparam logic [3:0] OP_MOV = 4'h8;
   localparam logic [3:0] OP_INC = 4'h9;
   localparam logic [3:0] OP_LDI = 4'hA;
   localparam logic [3:0] OP_XOR = 4'hB;

   localparam int unsigned FLG_Z = 0;
   localparam int unsigned FLG_G = 1;
   localparam int unsigned FLG_S = 2;
   localparam int unsigned FLG_C = 3;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StExec,
      StWb
   } state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: computes the width-extended result and says which flags
// and which destinations the op is allowed to update.
module exec_alu
   import exec_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] imm,
   output logic [WIDTH:0]   res,
   output logic [3:0]       flag_we,
   output logic             s_val,
   output logic             g_val,
   output logic             reg_we,
   output logic             res_we
);

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0] ax;
   logic [WIDTH:0] bx;

   assign ax = {1'b0, a};
   assign bx = {1'b0, b};

   always_comb begin
      res     = '0;
      flag_we = '0;
      s_val   = 1'b0;
      g_val   = 1'b0;
      reg_we  = 1'b1;
      res_we  = 1'b1;
      case (op)
         OP_ADD: begin
            res            = ax + bx;
            flag_we[FLG_C] = 1'b1;
         end
         OP_SUB: begin
            res            = ax - bx;
            flag_we[FLG_C] = 1'b1;
         end
         OP_AND: res = {1'b0, a & b};
         OP_OR:  res = {1'b0, a | b};
         OP_XOR: res = {1'b0, a ^ b};
         OP_SHL: begin
            res            = {a, 1'b0};
            s_val          = a[WIDTH-1];
            flag_we[FLG_S] = 1'b1;
         end
         OP_SHR: begin
            res            = {2'b00, a[WIDTH-1:1]};
            s_val          = a[0];
            flag_we[FLG_S] = 1'b1;
         end
         OP_CMP: begin
            // Low bits of a-b are zero exactly when a == b, so Z falls out below.
            res            = ax - bx;
            g_val          = (a > b);
            flag_we[FLG_G] = 1'b1;
            reg_we         = 1'b0;
         end
         OP_DEC: begin
            res            = ax - ONE;
            flag_we[FLG_C] = 1'b1;
         end
         OP_INC: begin
            res            = ax + ONE;
            flag_we[FLG_C] = 1'b1;
         end
         OP_MOV: res = ax;
         OP_LDI: res = {1'b0, imm};
         default: begin
            reg_we = 1'b0;
            res_we = 1'b0;
         end
      endcase
      flag_we[FLG_Z] = res_we;
   end

endmodule

// File: rtl/param_exec_unit.sv
// Register file plus ALU driven by a four-state start/done sequencer; operands
// are latched in FETCH and result, flags and register write land together.
module param_exec_unit
   import exec_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned NREGS  = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        op,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   input  logic [ADDR_W-1:0] dst,
   input  logic [WIDTH-1:0]  imm,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  result,
   output logic [3:0]        flags,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   localparam int unsigned NSLOTS = 1 << ADDR_W;

   state_t state_q, state_d;

   logic [3:0]        op_q;
   logic [ADDR_W-1:0] dst_q;
   logic [WIDTH-1:0]  imm_q;
   logic [WIDTH-1:0]  opa_q;
   logic [WIDTH-1:0]  opb_q;
   logic [WIDTH:0]    res_q;
   logic [3:0]        fwe_q;
   logic              s_q;
   logic              g_q;
   logic              reg_we_q;
   logic              res_we_q;
   logic [WIDTH-1:0]  result_q;
   logic [3:0]        flags_q;
   logic              done_q;
   logic [WIDTH-1:0]  regs_q [NREGS];

   logic [WIDTH-1:0]  rd_ext [NSLOTS];
   logic [WIDTH:0]    alu_res;
   logic [3:0]        alu_flag_we;
   logic              alu_s_val;
   logic              alu_g_val;
   logic              alu_reg_we;
   logic              alu_res_we;
   logic              wr_en;
   logic [3:0]        flags_new;

   // Pad the file out to the full address space so unpopulated slots read 0.
   for (genvar g = 0; g < NSLOTS; g++) begin : g_rd
      if (g < NREGS) begin : g_pop
         assign rd_ext[g] = regs_q[g];
      end else begin : g_empty
         assign rd_ext[g] = '0;
      end
   end

   assign rd_data = rd_ext[rd_addr];
   assign busy    = (state_q != StIdle);
   assign done    = done_q;
   assign result  = result_q;
   assign flags   = flags_q;
   assign wr_en   = (state_q == StWb) && reg_we_q;

   exec_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op      (op_q),
      .a       (opa_q),
      .b       (opb_q),
      .imm     (imm_q),
      .res     (alu_res),
      .flag_we (alu_flag_we),
      .s_val   (alu_s_val),
      .g_val   (alu_g_val),
      .reg_we  (alu_reg_we),
      .res_we  (alu_res_we)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StFetch;
         StFetch: state_d = StExec;
         StExec:  state_d = StWb;
         StWb:    state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      flags_new        = flags_q;
      if (fwe_q[FLG_C]) flags_new[FLG_C] = res_q[WIDTH];
      if (fwe_q[FLG_S]) flags_new[FLG_S] = s_q;
      if (fwe_q[FLG_G]) flags_new[FLG_G] = g_q;
      if (fwe_q[FLG_Z]) flags_new[FLG_Z] = (res_q[WIDTH-1:0] == '0);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_q     <= '0;
         dst_q    <= '0;
         imm_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         res_q    <= '0;
         fwe_q    <= '0;
         s_q      <= 1'b0;
         g_q      <= 1'b0;
         reg_we_q <= 1'b0;
         res_we_q <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_q == StWb);
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  op_q  <= op;
                  dst_q <= dst;
                  imm_q <= imm;
               end
            end
            StFetch: begin
               opa_q <= rd_ext[src_a];
               opb_q <= rd_ext[src_b];
            end
            StExec: begin
               res_q    <= alu_res;
               fwe_q    <= alu_flag_we;
               s_q      <= alu_s_val;
               g_q      <= alu_g_val;
               reg_we_q <= alu_reg_we;
               res_we_q <= alu_res_we;
            end
            StWb: begin
               if (res_we_q) result_q <= res_q[WIDTH-1:0];
               flags_q <= flags_new;
            end
            default: ;
         endcase
      end
   end

   // Destinations beyond NREGS match no entry, so the write is dropped.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < NREGS; i++) begin
            if (dst_q == ADDR_W'(i)) regs_q[i] <= res_q[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_param_exec_unit.sv
// Directed bench for param_exec_unit: default 8x8 instance plus a 16-bit,
// six-register instance exercising the out-of-range address path.
module tb_param_exec_unit;
   import exec_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [2:0]  src_a, src_b, dst, rd_addr;
   logic [7:0]  imm, result, rd_data;
   logic        busy, done;
   logic [3:0]  flags;

   logic        w_start;
   logic [3:0]  w_op;
   logic [2:0]  w_src_a, w_src_b, w_dst, w_rd_addr;
   logic [15:0] w_imm, w_result, w_rd_data;
   logic        w_busy, w_done;
   logic [3:0]  w_flags;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   param_exec_unit u_dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .src_a   (src_a),
      .src_b   (src_b),
      .dst     (dst),
      .imm     (imm),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .flags   (flags),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   param_exec_unit #(
      .WIDTH  (16),
      .NREGS  (6),
      .ADDR_W (3)
   ) u_dut16 (
      .clock   (clock),
      .reset   (reset),
      .start   (w_start),
      .op      (w_op),
      .src_a   (w_src_a),
      .src_b   (w_src_b),
      .dst     (w_dst),
      .imm     (w_imm),
      .busy    (w_busy),
      .done    (w_done),
      .result  (w_result),
      .flags   (w_flags),
      .rd_addr (w_rd_addr),
      .rd_data (w_rd_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic run_op(input logic [3:0] o, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] d, input logic [7:0] im);
      int cyc;
      @(negedge clock);
      op = o; src_a = a; src_b = b; dst = d; imm = im; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      cyc = 0;
      while (!done && cyc < 8) begin
         @(posedge clock);
         #1 cyc++;
      end
      check("latency", cyc, 3);
   endtask

   task automatic run_op16(input logic [3:0] o, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] d, input logic [15:0] im);
      int cyc;
      @(negedge clock);
      w_op = o; w_src_a = a; w_src_b = b; w_dst = d; w_imm = im; w_start = 1'b1;
      @(posedge clock);
      #1 w_start = 1'b0;
      cyc = 0;
      while (!w_done && cyc < 8) begin
         @(posedge clock);
         #1 cyc++;
      end
      check("latency16", cyc, 3);
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
      rd_addr = a;
      #1 check(tag, rd_data, exp);
   endtask

   task automatic check_reg16(input string tag, input logic [2:0] a, input logic [15:0] exp);
      w_rd_addr = a;
      #1 check(tag, w_rd_data, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation bound reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] busy_v, done_v;
      int         seen_done;
      reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0; imm = '0;
      rd_addr = '0;
      w_start = 1'b0; w_op = '0; w_src_a = '0; w_src_b = '0; w_dst = '0; w_imm = '0;
      w_rd_addr = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_flags", flags, 0);
      check_reg("rst_r0", 0, 8'h00);
      @(negedge clock) reset = 1'b0;

      run_op(OP_LDI, 0, 0, 1, 8'hC8);
      check("ldi_result", result, 8'hC8);
      run_op(OP_LDI, 0, 0, 2, 8'h64);
      run_op(OP_ADD, 1, 2, 3, 8'h00);
      check("add_result", result, 8'h2C);
      check("add_flags", flags, 4'b1000);
      check_reg("add_r3", 3, 8'h2C);

      run_op(OP_LDI, 0, 0, 4, 8'h05);
      run_op(OP_LDI, 0, 0, 5, 8'h05);
      run_op(OP_SUB, 4, 5, 6, 8'h00);
      check("sub_result", result, 8'h00);
      check("sub_flags", flags, 4'b0001);
      check_reg("sub_r6", 6, 8'h00);
      run_op(OP_DEC, 6, 0, 6, 8'h00);
      check("dec_result", result, 8'hFF);
      check("dec_flags", flags, 4'b1000);
      check_reg("dec_r6", 6, 8'hFF);

      run_op(OP_LDI, 0, 0, 1, 8'h81);
      run_op(OP_SHL, 1, 0, 2, 8'h00);
      check("shl_result", result, 8'h02);
      check("shl_flags", flags, 4'b1100);
      run_op(OP_SHR, 2, 0, 3, 8'h00);
      check("shr_result", result, 8'h01);
      check("shr_flags", flags, 4'b1000);
      check_reg("shr_r3", 3, 8'h01);

      run_op(OP_LDI, 0, 0, 4, 8'h10);
      run_op(OP_LDI, 0, 0, 5, 8'h0F);
      run_op(OP_CMP, 4, 5, 6, 8'h00);
      check("cmp_gt_flags", flags, 4'b1010);
      check_reg("cmp_r6", 6, 8'hFF);
      check_reg("cmp_r4", 4, 8'h10);
      run_op(OP_CMP, 4, 4, 6, 8'h00);
      check("cmp_eq_flags", flags, 4'b1001);
      check_reg("cmp_eq_r6", 6, 8'hFF);

      run_op(OP_OR, 4, 5, 7, 8'h00);
      check("or_result", result, 8'h1F);
      check("or_flags", flags, 4'b1000);
      run_op(4'hC, 4, 5, 7, 8'h33);
      check("nop_result", result, 8'h1F);
      check("nop_flags", flags, 4'b1000);
      check_reg("nop_r7", 7, 8'h1F);
      run_op(OP_INC, 6, 0, 7, 8'h00);
      check("inc_result", result, 8'h00);
      check("inc_flags", flags, 4'b1001);
      run_op(OP_XOR, 4, 5, 0, 8'h00);
      check("xor_r0", result, 8'h1F);
      check("xor_flags", flags, 4'b1000);
      run_op(OP_AND, 4, 5, 0, 8'h00);
      check("and_flags", flags, 4'b1001);
      check_reg("and_r0", 0, 8'h00);
      run_op(OP_MOV, 4, 0, 1, 8'h00);
      check_reg("mov_r1", 1, 8'h10);
      run_op(OP_ADD, 5, 5, 5, 8'h00);
      check_reg("self_add_r5", 5, 8'h1E);
      check("self_add_flags", flags, 4'b0000);

      // start held high: two INCs of r1, one every four cycles
      @(negedge clock);
      op = OP_INC; src_a = 1; src_b = 0; dst = 1; start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock);
         #1 busy_v[i] = busy;
         done_v[i] = done;
      end
      start = 1'b0;
      check("b2b_busy", busy_v, 8'h77);
      check("b2b_done", done_v, 8'h88);
      @(posedge clock);
      #1 check("b2b_idle", busy, 0);
      check_reg("b2b_r1", 1, 8'h12);

      // reset while the ADD into r7 is in EXEC
      run_op(OP_LDI, 0, 0, 7, 8'h55);
      @(negedge clock);
      op = OP_ADD; src_a = 1; src_b = 2; dst = 7; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_flags", flags, 0);
      check_reg("abort_r7", 7, 8'h00);
      @(negedge clock) reset = 1'b0;
      seen_done = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1 if (done) seen_done++;
      end
      check("abort_no_done", seen_done, 0);
      check_reg("abort_r7_after", 7, 8'h00);

      run_op16(OP_LDI, 0, 0, 1, 16'hFFFF);
      run_op16(OP_LDI, 0, 0, 2, 16'h0001);
      run_op16(OP_ADD, 1, 2, 3, 16'h0000);
      check("w_add_result", w_result, 16'h0000);
      check("w_add_flags", w_flags, 4'b1001);
      check_reg16("w_add_r3", 3, 16'h0000);
      run_op16(OP_LDI, 0, 0, 5, 16'hABCD);
      check_reg16("w_ldi_r5", 5, 16'hABCD);
      run_op16(OP_LDI, 0, 0, 7, 16'h1234);
      check_reg16("w_drop_r7", 7, 16'h0000);
      check_reg16("w_r6_zero", 6, 16'h0000);
      run_op16(OP_MOV, 7, 0, 4, 16'h0000);
      check_reg16("w_mov_oob", 4, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
